// File: rtl/ahb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_master_if
// Purpose  : AHB-Lite signal bundle between the burst master and the bridge
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_burst_master_if;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  modport master (
    output Htrans, Haddr, Hwrite, Hwdata, Hreadyin,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Htrans, Haddr, Hwrite, Hwdata, Hreadyin,
    output Hreadyout, Hresp, Hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_master
// Purpose  : command-driven AHB-Lite master issuing pipelined INCR word bursts
// Revision : 1.0 - initial release
// ============================================================================
module ahb_burst_master #(
  parameter int LEN_W = 4,
  parameter int BOUND = 1024
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             cmd_valid,
  output logic                  cmd_ready,
  input  wire logic             cmd_write,
  input  wire logic [31:0]      cmd_addr,
  input  wire logic [LEN_W-1:0] cmd_len,
  input  wire logic             wd_valid,
  input  wire logic [31:0]      wd_data,
  output logic                  wd_ready,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic                  done,
  output logic                  err,
  ahb_burst_master_if.master    ahb
);

  localparam int         c_BOUND_W = $clog2(BOUND);
  localparam logic [1:0] c_HT_IDLE = 2'b00;
  localparam logic [1:0] c_HT_BUSY = 2'b01;
  localparam logic [1:0] c_HT_NSEQ = 2'b10;
  localparam logic [1:0] c_HT_SEQ  = 2'b11;
  localparam logic [LEN_W:0] c_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr;
  logic [LEN_W:0]   r_remaining;
  logic             r_write, r_err, r_issued;
  logic             r_dp_pend, r_dp_write;
  logic [31:0]      r_wbuf;
  logic [1:0]       r_htrans;
  logic [31:0]      r_haddr, r_hwdata;
  logic             r_hwrite;

  logic w_adv, w_acc, w_dp_done, w_resp_err, w_stop;
  logic w_accept, w_issue, w_done;

  assign w_adv      = ahb.Hreadyout;
  assign w_acc      = w_adv & r_htrans[1];
  assign w_dp_done  = w_adv & r_dp_pend;
  assign w_resp_err = w_dp_done & (ahb.Hresp != 2'b00);
  // An error response stops new address phases from the same cycle onward
  assign w_stop     = r_err | w_resp_err;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_adv) begin
          if ((r_remaining == '0) || w_stop) begin
            w_state_nxt = S_DRAIN;
          end else if (!r_write || wd_valid) begin
            w_issue = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!r_dp_pend || w_adv) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_issued    <= 1'b0;
      r_dp_pend   <= 1'b0;
      r_dp_write  <= 1'b0;
      r_wbuf      <= '0;
      r_htrans    <= c_HT_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr      <= cmd_addr & 32'hFFFF_FFFC;
        r_remaining <= {1'b0, cmd_len} + c_ONE;
        r_write     <= cmd_write;
        r_err       <= 1'b0;
        r_issued    <= 1'b0;
      end else if (w_resp_err) begin
        r_err <= 1'b1;
      end
      if (w_adv) begin
        r_dp_pend  <= w_acc;
        r_dp_write <= r_hwrite;
        // Second stage of the write-data double buffer
        if (w_acc && r_hwrite) begin
          r_hwdata <= r_wbuf;
        end
      end
      if (r_state == S_BURST && w_adv) begin
        if (w_issue) begin
          r_htrans    <= (!r_issued || r_addr[c_BOUND_W-1:0] == '0) ? c_HT_NSEQ : c_HT_SEQ;
          r_haddr     <= r_addr;
          r_hwrite    <= r_write;
          r_addr      <= r_addr + 32'd4;
          r_remaining <= r_remaining - c_ONE;
          r_issued    <= 1'b1;
          if (r_write) begin
            r_wbuf <= wd_data;
          end
        end else if (w_state_nxt == S_DRAIN) begin
          r_htrans <= c_HT_IDLE;
        end else begin
          r_htrans <= r_issued ? c_HT_BUSY : c_HT_IDLE;
          r_haddr  <= r_addr;
          r_hwrite <= r_write;
        end
      end
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign wd_ready     = w_issue & r_write;
  assign rd_valid     = w_dp_done & ~r_dp_write;
  assign rd_data      = rd_valid ? ahb.Hrdata : 32'd0;
  assign done         = w_done;
  assign err          = r_err | w_resp_err;

  assign ahb.Htrans   = r_htrans;
  assign ahb.Haddr    = r_haddr;
  assign ahb.Hwrite   = r_hwrite;
  assign ahb.Hwdata   = r_hwdata;
  assign ahb.Hreadyin = ahb.Hreadyout;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_burst_master
// Purpose  : directed self-checking bench for ahb_burst_master
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready, rd_valid, done, err;
  logic [31:0] wd_data, rd_data;

  ahb_burst_master_if bus ();

  ahb_burst_master #(.LEN_W(4), .BOUND(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_data   (wd_data),
    .wd_ready  (wd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .ahb       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        pat_rdy  [0:63];
  logic        pat_wdv  [0:63];
  logic [1:0]  pat_resp [0:63];
  logic [31:0] wq       [0:15];
  int          wptr, rcnt, n_wdr, n_rdv, n_done;

  logic [1:0]  lg_ht  [0:63];
  logic [31:0] lg_ad  [0:63];
  logic        lg_wr  [0:63];
  logic [31:0] lg_wd  [0:63];
  logic        lg_wdr [0:63];
  logic        lg_rdv [0:63];
  logic [31:0] lg_rdd [0:63];
  logic        lg_dn  [0:63];
  logic        lg_er  [0:63];
  logic        lg_rin [0:63];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pat(input logic wdv);
    for (int i = 0; i < 64; i++) begin
      pat_rdy[i]  = 1'b1;
      pat_wdv[i]  = wdv;
      pat_resp[i] = 2'b00;
    end
    for (int i = 0; i < 16; i++) wq[i] = 32'h1111_1111 * (i + 1);
  endtask

  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_value("cmd_ready_before_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accepting clock edge
  task automatic run(input int n);
    wptr = 0; rcnt = 0; n_wdr = 0; n_rdv = 0; n_done = 0;
    for (int i = 1; i <= n; i++) begin
      bus.Hreadyout = pat_rdy[i];
      bus.Hresp     = pat_resp[i];
      bus.Hrdata    = rcnt;
      wd_valid      = pat_wdv[i];
      wd_data       = wq[wptr];
      @(negedge clk);
      lg_ht[i]  = bus.Htrans;  lg_ad[i]  = bus.Haddr;  lg_wr[i] = bus.Hwrite;
      lg_wd[i]  = bus.Hwdata;  lg_wdr[i] = wd_ready;   lg_rdv[i] = rd_valid;
      lg_rdd[i] = rd_data;     lg_dn[i]  = done;       lg_er[i] = err;
      lg_rin[i] = bus.Hreadyin;
      if (wd_ready) begin n_wdr++; wptr++; end
      if (rd_valid) begin n_rdv++; rcnt++; end
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    wd_valid      = 1'b0;
  endtask

  initial begin
    logic [1:0]  exp_ht [0:3];
    logic [31:0] exp_ad [0:3];

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    bus.Hreadyout = 1'b1; bus.Hresp = 2'b00; bus.Hrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("rst_htrans", bus.Htrans, 2'b00);
    check_value("rst_haddr", bus.Haddr, 32'h0);
    check_value("rst_hwrite", bus.Hwrite, 1'b0);
    check_value("rst_hwdata", bus.Hwdata, 32'h0);
    check_value("rst_flags", {cmd_ready, wd_ready, rd_valid, done, err}, 5'b10000);
    @(posedge clk);
    #1;

    // Single-beat write
    set_pat(1'b1);
    wq[0] = 32'hA5A5_A5A5;
    start_cmd(1'b1, 32'h0000_0100, 4'd0);
    run(3);
    check_value("w1_c1_wd_ready", lg_wdr[1], 1'b1);
    check_value("w1_c2_htrans", lg_ht[2], 2'b10);
    check_value("w1_c2_haddr", lg_ad[2], 32'h100);
    check_value("w1_c2_hwrite", lg_wr[2], 1'b1);
    check_value("w1_c2_done", lg_dn[2], 1'b0);
    check_value("w1_c3_hwdata", lg_wd[3], 32'hA5A5_A5A5);
    check_value("w1_c3_done_err", {lg_dn[3], lg_er[3]}, 2'b10);
    check_value("w1_c3_htrans", lg_ht[3], 2'b00);
    check_value("w1_wd_ready_count", n_wdr, 1);

    // 4-beat read
    set_pat(1'b0);
    start_cmd(1'b0, 32'h0000_2000, 4'd3);
    run(7);
    exp_ht = '{2'b10, 2'b11, 2'b11, 2'b11};
    for (int b = 0; b < 4; b++) begin
      check_value($sformatf("r4_htrans_b%0d", b), lg_ht[2+b], exp_ht[b]);
      check_value($sformatf("r4_haddr_b%0d", b), lg_ad[2+b], 32'h2000 + 4*b);
      check_value($sformatf("r4_rd_valid_b%0d", b), lg_rdv[3+b], 1'b1);
      check_value($sformatf("r4_rd_data_b%0d", b), lg_rdd[3+b], b);
    end
    check_value("r4_c6_htrans", lg_ht[6], 2'b00);
    check_value("r4_c6_done", lg_dn[6], 1'b1);
    check_value("r4_rd_count", n_rdv, 4);
    check_value("r4_done_count", n_done, 1);

    // Write with wd_valid low for two cycles before beat 3
    set_pat(1'b1);
    pat_wdv[3] = 1'b0;
    pat_wdv[4] = 1'b0;
    start_cmd(1'b1, 32'h0000_0040, 4'd3);
    run(9);
    check_value("wb_c4_htrans", lg_ht[4], 2'b01);
    check_value("wb_c5_htrans", lg_ht[5], 2'b01);
    check_value("wb_c4_haddr", lg_ad[4], 32'h48);
    check_value("wb_c5_haddr", lg_ad[5], 32'h48);
    check_value("wb_c6_htrans_haddr", {lg_ht[6], lg_ad[6]}, {2'b11, 32'h48});
    check_value("wb_hwdata_b0", lg_wd[3], 32'h1111_1111);
    check_value("wb_hwdata_b1", lg_wd[4], 32'h2222_2222);
    check_value("wb_hwdata_b2", lg_wd[7], 32'h3333_3333);
    check_value("wb_hwdata_b3", lg_wd[8], 32'h4444_4444);
    check_value("wb_wd_ready_count", n_wdr, 4);
    check_value("wb_c8_done", lg_dn[8], 1'b1);
    check_value("wb_done_count", n_done, 1);

    // Hreadyout low for three cycles mid-read
    set_pat(1'b0);
    pat_rdy[4] = 1'b0; pat_rdy[5] = 1'b0; pat_rdy[6] = 1'b0;
    start_cmd(1'b0, 32'h0000_0500, 4'd3);
    run(10);
    for (int c = 4; c <= 6; c++) begin
      check_value($sformatf("st_c%0d_htrans_haddr", c), {lg_ht[c], lg_ad[c]}, {2'b11, 32'h508});
      check_value($sformatf("st_c%0d_rd_valid", c), lg_rdv[c], 1'b0);
      check_value($sformatf("st_c%0d_hreadyin", c), lg_rin[c], 1'b0);
    end
    check_value("st_c7_rd", {lg_rdv[7], lg_rdd[7]}, {1'b1, 32'd1});
    check_value("st_c8_haddr", lg_ad[8], 32'h50C);
    check_value("st_c9_done", lg_dn[9], 1'b1);
    check_value("st_rd_count", n_rdv, 4);

    // Burst crossing the 1 KB boundary
    set_pat(1'b0);
    start_cmd(1'b0, 32'h0000_03F8, 4'd3);
    run(7);
    exp_ht = '{2'b10, 2'b11, 2'b10, 2'b11};
    exp_ad = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    for (int b = 0; b < 4; b++) begin
      check_value($sformatf("bd_htrans_b%0d", b), lg_ht[2+b], exp_ht[b]);
      check_value($sformatf("bd_haddr_b%0d", b), lg_ad[2+b], exp_ad[b]);
    end

    // Error response on beat 2 of an 8-beat write
    set_pat(1'b1);
    pat_resp[4] = 2'b01;
    start_cmd(1'b1, 32'h0000_0600, 4'd7);
    run(6);
    check_value("er_c4_htrans", lg_ht[4], 2'b11);
    check_value("er_c5_htrans", lg_ht[5], 2'b00);
    check_value("er_c6_htrans", lg_ht[6], 2'b00);
    check_value("er_c5_hwdata", lg_wd[5], 32'h3333_3333);
    check_value("er_c5_done_err", {lg_dn[5], lg_er[5]}, 2'b11);
    check_value("er_done_count", n_done, 1);
    check_value("er_wd_ready_count", n_wdr, 3);
    @(negedge clk);
    check_value("er_cmd_ready_after", cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of a burst
    set_pat(1'b0);
    start_cmd(1'b0, 32'h0000_0700, 4'd7);
    run(3);
    check_value("rs_c3_htrans", lg_ht[3], 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check_value("rs_done_during", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("rs_htrans_after", bus.Htrans, 2'b00);
    check_value("rs_flags_after", {cmd_ready, done, rd_valid}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
